lc3_mem_responder: RTL and testbench
====================================

Name: lc3_mem_responder

Overview:
Memory-side responder for the LC-3 datapath's MAR/MDR bus. It serves CPU reads and writes to a word-addressed RAM and to four memory-mapped device registers: keyboard status/data and display status/data. It also runs the keyboard-input and display-output handshakes. It sits opposite the CPU controller on the memory interface: the CPU initiates, this block responds.

Parameters:
ADDR_W, 10, RAM address width; RAM holds 2^ADDR_W 16-bit words at 0x0000..2^ADDR_W-1
DISP_BUSY_CYC, 4, display busy cycles after each accepted character (0 allowed)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
addr  input  16  word address (CPU MAR)
din  input  16  write data (CPU MDR)
we  input  1  write strobe (CPU memWE)
re  input  1  read strobe (CPU MDR load from memory); used only for read side effects
dout  output  16  read data, combinational from addr and register state
kb_valid  input  1  keyboard character offered
kb_data  input  8  keyboard character
kb_ready  output  1  responder can accept a character
disp_valid  output  1  display character offered
disp_data  output  8  display character
disp_ready  input  1  display accepts the character

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst, and takes priority over all other activity.
- Reset values:
  - KBSR = 0x0000, KBDR = 0x0000.
  - DSR[15] = 1 (display idle).
  - disp_valid = 0, disp_data = 0x00, busy counter = 0.
  - kb_ready = 1.
  - RAM contents are not reset.
- Address map:
  - 0x0000..2^ADDR_W-1: RAM.
  - 0xFE00 KBSR: bit 15 = ready, other bits 0.
  - 0xFE02 KBDR: {8'h00, char}.
  - 0xFE04 DSR: bit 15 = ready.
  - 0xFE06 DDR: reads 0x0000.
  - Any other address: reads 0x0000, writes dropped.
- Reads: dout is combinational from addr with zero-cycle latency. The CPU samples it during its MDR-load cycle, the cycle after MAR loads.
- RAM writes: when we=1, RAM[addr] <= din at the clock edge. A read of the same address returns new data starting the following cycle.
- Keyboard path:
  - kb_ready = ~KBSR[15].
  - On kb_valid & kb_ready at a clock edge: KBDR <= {8'h00, kb_data} and KBSR[15] <= 1.
  - re=1 with addr=0xFE02 clears KBSR[15] at the edge. kb_ready rises the next cycle.
  - No overrun is possible: a new character is never accepted while KBSR[15]=1.
- Display state machine, states IDLE, SEND, BUSY:
  - IDLE (DSR[15]=1): we=1 with addr=0xFE06 latches disp_data <= din[7:0], sets disp_valid=1 and DSR[15]=0, and moves to SEND.
  - SEND: hold disp_valid and disp_data stable until disp_ready=1. On that handshake edge, disp_valid <= 0 and the counter loads DISP_BUSY_CYC.
    - If DISP_BUSY_CYC = 0: go directly to IDLE.
    - Otherwise: go to BUSY.
  - BUSY: counter decrements by 1 each cycle. When the counter reaches 1, the next edge sets DSR[15]=1 and the state returns to IDLE. DSR therefore reads ready exactly DISP_BUSY_CYC cycles after the handshake edge.
  - A write to DDR in SEND or BUSY is dropped.
  - Writes to KBSR, KBDR and DSR are ignored (see Optional Feature for the exception).
- Simultaneous events:
  - we and re in the same cycle: the write commits and the read side effect also applies.
  - rst asserted mid-handshake: disp_valid drops at that edge and the held character is discarded.

Optional Feature:
LC3_MEM_IRQ_EN
- Defined:
  - KBSR[14] and DSR[14] become interrupt-enable bits, writable via we to 0xFE00 and 0xFE04 (only bit 14 is written). Both reset to 0.
  - Adds output irq (1 bit) = (KBSR[15] & KBSR[14]) | (DSR[15] & DSR[14]), registered, with 1-cycle latency.
- Undefined: no irq port, bit 14 reads 0, and status writes are ignored.

Test Plan:
- Reset, then RAM access: write 0x1234 to addr 0x0005, then read addr 0x0005 → dout=0x1234 from the next cycle; read addr 0x4000 → 0x0000.
- Keyboard: kb_valid=1 with kb_data=0x41 → next cycle KBSR reads 0x8000, KBDR reads 0x0041, kb_ready=0. Offer 0x42 → not accepted. Read 0xFE02 with re=1 → KBSR 0x0000 the next cycle, kb_ready=1.
- Display: write 0x0058 to 0xFE06 → disp_valid=1, disp_data=0x58, DSR=0x0000. Hold disp_ready=0 for 3 cycles → outputs stable. Assert disp_ready → disp_valid=0, and DSR=0x8000 exactly 4 cycles after the handshake.
- Dropped write: write 0x0059 to DDR while BUSY → disp_data remains 0x58 and no new disp_valid.
- Reset mid-SEND: assert rst while disp_valid=1 → next cycle disp_valid=0, DSR=0x8000, KBSR=0x0000.
- (LC3_MEM_IRQ_EN) Write 0x4000 to 0xFE04 → irq=1 one cycle later, since the display is idle.

Source files
------------

// File: rtl/lc3_mem_responder.sv
// LC-3 memory-side responder: word RAM plus KBSR/KBDR/DSR/DDR device registers.
// Optional macro LC3_MEM_IRQ_EN adds status interrupt-enable bits and an irq output.
module lc3_mem_responder #(
  parameter int ADDR_W        = 10,
  parameter int DISP_BUSY_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] din,
  input  logic        we,
  input  logic        re,
  output logic [15:0] dout,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_ready,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ready
`ifdef LC3_MEM_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
  localparam logic [15:0] BUSY_LOAD = 16'(DISP_BUSY_CYC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    BUSY = 2'd2
  } disp_state_t;

  logic [15:0]      mem [0:(2**ADDR_W)-1];
  logic             in_ram;
  logic             kbsr_ready;
  logic [7:0]       kbdr_char;
  logic             dsr_ready;
  logic             kb_ie;
  logic             dsr_ie;
  logic [15:0]      busy_cnt;
  disp_state_t      disp_state;

  assign in_ram   = ((addr >> ADDR_W) == 16'd0);
  assign kb_ready = ~kbsr_ready;

  // RAM write port; contents intentionally not reset
  always_ff @(posedge clk) begin
    if (we && in_ram) begin
      mem[addr[ADDR_W-1:0]] <= din;
    end
  end

  // combinational read mux over RAM and device registers
  always_comb begin
    dout = 16'h0000;
    if (in_ram) begin
      dout = mem[addr[ADDR_W-1:0]];
    end else begin
      case (addr)
        KBSR_ADDR: dout = {kbsr_ready, kb_ie, 14'h0000};
        KBDR_ADDR: dout = {8'h00, kbdr_char};
        DSR_ADDR:  dout = {dsr_ready, dsr_ie, 14'h0000};
        default:   dout = 16'h0000;
      endcase
    end
  end

  // keyboard capture; accept only while empty, so no overrun can occur
  always_ff @(posedge clk) begin
    if (rst) begin
      kbsr_ready <= 1'b0;
      kbdr_char  <= 8'h00;
    end else if (kb_valid && !kbsr_ready) begin
      kbsr_ready <= 1'b1;
      kbdr_char  <= kb_data;
    end else if (re && (addr == KBDR_ADDR)) begin
      kbsr_ready <= 1'b0;
    end else begin
      kbsr_ready <= kbsr_ready;
    end
  end

  // display handshake FSM; DSR returns ready DISP_BUSY_CYC cycles after handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_state <= IDLE;
      disp_valid <= 1'b0;
      disp_data  <= 8'h00;
      dsr_ready  <= 1'b1;
      busy_cnt   <= 16'd0;
    end else begin
      case (disp_state)
        IDLE: begin
          if (we && (addr == DDR_ADDR)) begin
            disp_data  <= din[7:0];
            disp_valid <= 1'b1;
            dsr_ready  <= 1'b0;
            disp_state <= SEND;
          end
        end
        SEND: begin
          if (disp_ready) begin
            disp_valid <= 1'b0;
            busy_cnt   <= BUSY_LOAD;
            if (BUSY_LOAD == 16'd0) begin
              dsr_ready  <= 1'b1;
              disp_state <= IDLE;
            end else begin
              disp_state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (busy_cnt <= 16'd1) begin
            busy_cnt   <= 16'd0;
            dsr_ready  <= 1'b1;
            disp_state <= IDLE;
          end else begin
            busy_cnt <= busy_cnt - 16'd1;
          end
        end
        default: begin
          disp_state <= IDLE;
          disp_valid <= 1'b0;
          dsr_ready  <= 1'b1;
          busy_cnt   <= 16'd0;
        end
      endcase
    end
  end

`ifdef LC3_MEM_IRQ_EN
  // interrupt-enable bits (bit 14 only) and registered interrupt request
  always_ff @(posedge clk) begin
    if (rst) begin
      kb_ie  <= 1'b0;
      dsr_ie <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (we && (addr == KBSR_ADDR)) begin
        kb_ie <= din[14];
      end
      if (we && (addr == DSR_ADDR)) begin
        dsr_ie <= din[14];
      end
      irq <= (kbsr_ready & kb_ie) | (dsr_ready & dsr_ie);
    end
  end
`else
  assign kb_ie  = 1'b0;
  assign dsr_ie = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed self-checking bench for lc3_mem_responder (default parameters).
module tb_lc3_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] din;
  logic        we;
  logic        re;
  logic [15:0] dout;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        kb_ready;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        disp_ready;
`ifdef LC3_MEM_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lc3_mem_responder #(.ADDR_W(10), .DISP_BUSY_CYC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .din        (din),
    .we         (we),
    .re         (re),
    .dout       (dout),
    .kb_valid   (kb_valid),
    .kb_data    (kb_data),
    .kb_ready   (kb_ready),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .disp_ready (disp_ready)
`ifdef LC3_MEM_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    addr = a;
    #1;
    check_val(tag, dout, exp);
  endtask

  task automatic write_cyc(input logic [15:0] a, input logic [15:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr = 16'h0000; din = 16'h0000; we = 1'b0; re = 1'b0;
    kb_valid = 1'b0; kb_data = 8'h00; disp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    check_val("rst_kb_ready", {15'd0, kb_ready}, 16'h0001);
    check_val("rst_disp_valid", {15'd0, disp_valid}, 16'h0000);
    check_val("rst_disp_data", {8'd0, disp_data}, 16'h0000);
    read_chk("rst_kbsr", 16'hFE00, 16'h0000);
    read_chk("rst_kbdr", 16'hFE02, 16'h0000);
    read_chk("rst_dsr", 16'hFE04, 16'h8000);
    read_chk("rst_ddr", 16'hFE06, 16'h0000);

    // RAM write/read, top-of-RAM boundary, out-of-range addresses
    write_cyc(16'h0005, 16'h1234);
    read_chk("ram_5", 16'h0005, 16'h1234);
    write_cyc(16'h03FF, 16'hBEEF);
    read_chk("ram_3ff", 16'h03FF, 16'hBEEF);
    write_cyc(16'h0000, 16'h1111);
    write_cyc(16'h0400, 16'hDEAD);
    read_chk("ram_0_no_alias", 16'h0000, 16'h1111);
    read_chk("oob_400", 16'h0400, 16'h0000);
    read_chk("oob_4000", 16'h4000, 16'h0000);
    read_chk("ram_5_keep", 16'h0005, 16'h1234);

    // keyboard accept
    kb_valid = 1'b1; kb_data = 8'h41;
    tick();
    kb_valid = 1'b0;
    read_chk("kb_kbsr_full", 16'hFE00, 16'h8000);
    read_chk("kb_kbdr", 16'hFE02, 16'h0041);
    check_val("kb_ready_low", {15'd0, kb_ready}, 16'h0000);
    // second char while full is refused
    kb_valid = 1'b1; kb_data = 8'h42;
    tick();
    kb_valid = 1'b0;
    read_chk("kb_no_overrun", 16'hFE02, 16'h0041);
    // reading KBDR with re clears ready
    addr = 16'hFE02; re = 1'b1;
    tick();
    re = 1'b0;
    read_chk("kb_kbsr_clr", 16'hFE00, 16'h0000);
    check_val("kb_ready_high", {15'd0, kb_ready}, 16'h0001);
    read_chk("kb_kbdr_keep", 16'hFE02, 16'h0041);

    // display output
    write_cyc(16'hFE06, 16'h0058);
    check_val("disp_valid_set", {15'd0, disp_valid}, 16'h0001);
    check_val("disp_data_set", {8'd0, disp_data}, 16'h0058);
    read_chk("disp_dsr_busy", 16'hFE04, 16'h0000);
    read_chk("disp_ddr_read", 16'hFE06, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("disp_hold_valid", {15'd0, disp_valid}, 16'h0001);
      check_val("disp_hold_data", {8'd0, disp_data}, 16'h0058);
    end
    disp_ready = 1'b1;
    tick();
    disp_ready = 1'b0;
    check_val("disp_hs_valid", {15'd0, disp_valid}, 16'h0000);
    read_chk("disp_dsr_h0", 16'hFE04, 16'h0000);
    // DDR write while BUSY is dropped
    write_cyc(16'hFE06, 16'h0059);
    check_val("disp_drop_valid", {15'd0, disp_valid}, 16'h0000);
    check_val("disp_drop_data", {8'd0, disp_data}, 16'h0058);
    read_chk("disp_dsr_h1", 16'hFE04, 16'h0000);
    tick();
    read_chk("disp_dsr_h2", 16'hFE04, 16'h0000);
    tick();
    read_chk("disp_dsr_h3", 16'hFE04, 16'h0000);
    tick();
    read_chk("disp_dsr_h4", 16'hFE04, 16'h8000);
    check_val("disp_idle_valid", {15'd0, disp_valid}, 16'h0000);

    // reset in the middle of SEND, keyboard full
    kb_valid = 1'b1; kb_data = 8'h7A;
    write_cyc(16'hFE06, 16'h0041);
    kb_valid = 1'b0;
    check_val("mid_valid", {15'd0, disp_valid}, 16'h0001);
    check_val("mid_kb_ready", {15'd0, kb_ready}, 16'h0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rst2_valid", {15'd0, disp_valid}, 16'h0000);
    check_val("rst2_data", {8'd0, disp_data}, 16'h0000);
    read_chk("rst2_dsr", 16'hFE04, 16'h8000);
    read_chk("rst2_kbsr", 16'hFE00, 16'h0000);
    check_val("rst2_kb_ready", {15'd0, kb_ready}, 16'h0001);

`ifdef LC3_MEM_IRQ_EN
    check_val("irq_rst", {15'd0, irq}, 16'h0000);
    write_cyc(16'hFE04, 16'h4000);
    check_val("irq_before", {15'd0, irq}, 16'h0000);
    read_chk("irq_dsr_ie", 16'hFE04, 16'hC000);
    tick();
    check_val("irq_set", {15'd0, irq}, 16'h0001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
